// File: rtl/acq_search_ctrl.sv
// GPS acquisition search controller: sweeps Doppler bins x code phases, confirms the peak, reports lock.
// Optional ACQ_PEAK_MAG_EN adds peak_mag_o exposing the stored best magnitude.
module acq_search_ctrl #(
   parameter int MAG_W           = 24,
   parameter int NUM_BINS        = 21,
   parameter int DOPPLER_STEP_HZ = 500,
   parameter int MAX_RETRY       = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [5:0]        sv_id_i,
   input  logic [MAG_W-1:0]  threshold_i,
   output logic [4:0]        bin_o,
   output logic [9:0]        phase_o,
   input  logic              corr_valid_i,
   output logic              corr_ready_o,
   input  logic [MAG_W-1:0]  corr_mag_i,
   output logic [2:0]        state_o,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [31:0]       res_o,
   output logic              fail_o
`ifdef ACQ_PEAK_MAG_EN
   ,
   output logic [MAG_W-1:0]  peak_mag_o
`endif
);

   typedef enum logic [2:0] {
      ACQ_IDLE    = 3'd0,
      ACQ_SEARCH  = 3'd1,
      ACQ_CONFIRM = 3'd2,
      ACQ_LOCKED  = 3'd3,
      ACQ_TIMEOUT = 3'd4
   } acq_state_e;

   localparam int         RW         = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int         HALF_BINS  = (NUM_BINS - 1) / 2;
   localparam logic [4:0] LAST_BIN   = 5'(NUM_BINS - 1);
   localparam logic [9:0] LAST_PHASE = 10'd1022;

   acq_state_e        state_q, state_d;
   logic [5:0]        sv_q, sv_d;
   logic [MAG_W-1:0]  thr_q, thr_d;
   logic [4:0]        bin_q, bin_d;
   logic [9:0]        phase_q, phase_d;
   logic [MAG_W-1:0]  best_q, best_d;
   logic [4:0]        best_bin_q, best_bin_d;
   logic [9:0]        best_phase_q, best_phase_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [31:0]       res_q, res_d;

   logic              accept;
   logic              new_best;
   logic [MAG_W-1:0]  cand_mag;
   logic [4:0]        cand_bin;
   logic [9:0]        cand_phase;
   logic [15:0]       doppler_hz;

   assign corr_ready_o = (state_q == ACQ_SEARCH) || (state_q == ACQ_CONFIRM);
   assign accept       = corr_valid_i && corr_ready_o;
   // Strict compare keeps the earliest cell on ties; the final cell's sample counts toward the decision.
   assign new_best     = accept && (corr_mag_i > best_q);
   assign cand_mag     = new_best ? corr_mag_i : best_q;
   assign cand_bin     = new_best ? bin_q      : best_bin_q;
   assign cand_phase   = new_best ? phase_q    : best_phase_q;
   assign doppler_hz   = 16'((32'(best_bin_q) - 32'(HALF_BINS)) * 32'(DOPPLER_STEP_HZ));

   always_comb begin
      state_d      = state_q;
      sv_d         = sv_q;
      thr_d        = thr_q;
      bin_d        = bin_q;
      phase_d      = phase_q;
      best_d       = best_q;
      best_bin_d   = best_bin_q;
      best_phase_d = best_phase_q;
      retry_d      = retry_q;
      res_d        = res_q;
      case (state_q)
         ACQ_IDLE: begin
            if (start_i) begin
               sv_d         = sv_id_i;
               thr_d        = threshold_i;
               bin_d        = '0;
               phase_d      = '0;
               best_d       = '0;
               best_bin_d   = '0;
               best_phase_d = '0;
               retry_d      = '0;
               state_d      = ACQ_SEARCH;
            end
         end
         ACQ_SEARCH: begin
            if (accept) begin
               best_d       = cand_mag;
               best_bin_d   = cand_bin;
               best_phase_d = cand_phase;
               if (bin_q == LAST_BIN && phase_q == LAST_PHASE) begin
                  bin_d   = cand_bin;
                  phase_d = cand_phase;
                  state_d = (cand_mag > thr_q) ? ACQ_CONFIRM : ACQ_TIMEOUT;
               end else if (phase_q == LAST_PHASE) begin
                  phase_d = '0;
                  bin_d   = bin_q + 5'd1;
               end else begin
                  phase_d = phase_q + 10'd1;
               end
            end
         end
         ACQ_CONFIRM: begin
            if (accept) begin
               if (corr_mag_i > thr_q) begin
                  res_d   = {sv_q, doppler_hz, best_phase_q};
                  state_d = ACQ_LOCKED;
               end else begin
                  retry_d = retry_q + RW'(1);
                  if (retry_q == RW'(MAX_RETRY - 1)) state_d = ACQ_TIMEOUT;
               end
            end
         end
         ACQ_LOCKED: begin
            if (res_ready_i) state_d = ACQ_IDLE;
         end
         ACQ_TIMEOUT: state_d = ACQ_IDLE;
         default:     state_d = ACQ_IDLE;
      endcase
      if (abort_i) state_d = ACQ_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ACQ_IDLE;
         sv_q         <= '0;
         thr_q        <= '0;
         bin_q        <= '0;
         phase_q      <= '0;
         best_q       <= '0;
         best_bin_q   <= '0;
         best_phase_q <= '0;
         retry_q      <= '0;
         res_q        <= '0;
      end else begin
         state_q      <= state_d;
         sv_q         <= sv_d;
         thr_q        <= thr_d;
         bin_q        <= bin_d;
         phase_q      <= phase_d;
         best_q       <= best_d;
         best_bin_q   <= best_bin_d;
         best_phase_q <= best_phase_d;
         retry_q      <= retry_d;
         res_q        <= res_d;
      end
   end

   assign state_o     = state_q;
   assign bin_o       = bin_q;
   assign phase_o     = phase_q;
   assign res_valid_o = (state_q == ACQ_LOCKED);
   assign fail_o      = (state_q == ACQ_TIMEOUT);
   assign res_o       = res_q;
`ifdef ACQ_PEAK_MAG_EN
   assign peak_mag_o  = best_q;
`endif

endmodule

// File: doc/acq_search_ctrl.md
ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

Interface
REQ-001 SHALL have parameter MAG_W, default 24, correlator magnitude width in bits.
REQ-002 SHALL have parameter NUM_BINS, default 21, Doppler bins searched (odd, 3..31).
REQ-003 SHALL have parameter DOPPLER_STEP_HZ, default 500, Doppler bin spacing in Hz.
REQ-004 SHALL have parameter MAX_RETRY, default 3, confirm attempts before timeout.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_i  in  1  start search; sampled only in ACQ_IDLE.
REQ-008 SHALL have port abort_i  in  1  abandon current search.
REQ-009 SHALL have port sv_id_i  in  6  satellite ID; captured on start.
REQ-010 SHALL have port threshold_i  in  MAG_W  detection threshold; captured on start.
REQ-011 SHALL have port bin_o  out  5  Doppler bin requested from correlator.
REQ-012 SHALL have port phase_o  out  10  code phase requested from correlator, 0..1022.
REQ-013 SHALL have port corr_valid_i  in  1  correlator magnitude valid.
REQ-014 SHALL have port corr_ready_o  out  1  block accepts magnitude.
REQ-015 SHALL have port corr_mag_i  in  MAG_W  unsigned magnitude for (bin_o, phase_o).
REQ-016 SHALL have port state_o  out  3  current acq_state_e from gps_core_pkg.
REQ-017 SHALL have port res_valid_o  out  1  lock result valid.
REQ-018 SHALL have port res_ready_i  in  1  downstream tracking accepts result.
REQ-019 SHALL have port res_o  out  32  sat_status_s {sv_id, doppler_hz, code_phase}.
REQ-020 SHALL have port fail_o  out  1  one-cycle pulse on search failure.

Function
REQ-021 SHALL treat a sample as accepted only on a cycle where corr_valid_i and corr_ready_o are both 1.
REQ-022 SHALL drive corr_ready_o=1 only in ACQ_SEARCH and ACQ_CONFIRM.
REQ-023 In ACQ_IDLE with start_i=1, SHALL capture sv_id_i/threshold_i, clear bin, phase, best magnitude, retry count, and enter ACQ_SEARCH next cycle.
REQ-024 In ACQ_SEARCH, SHALL update best magnitude/bin/phase when an accepted sample is strictly greater than the stored best (ties keep the earliest cell).
REQ-025 SHALL advance phase_o by 1 per accepted sample, wrapping 1022->0 with bin_o incremented on the wrap.
REQ-026 On the accepted sample at bin NUM_BINS-1, phase 1022, SHALL go to ACQ_CONFIRM if best > threshold (the final sample included), else ACQ_TIMEOUT.
REQ-027 In ACQ_CONFIRM, SHALL hold bin_o/phase_o at the best cell; an accepted sample > threshold goes to ACQ_LOCKED, otherwise retry count increments.
REQ-028 SHALL go from ACQ_CONFIRM to ACQ_TIMEOUT on the MAX_RETRY-th failed confirm sample.
REQ-029 In ACQ_LOCKED, SHALL hold res_valid_o=1 and res_o stable until res_ready_i=1, then enter ACQ_IDLE next cycle.
REQ-030 SHALL compute doppler_hz as 16-bit two's complement (best_bin - (NUM_BINS-1)/2) * DOPPLER_STEP_HZ.
REQ-031 ACQ_TIMEOUT SHALL last exactly one cycle with fail_o=1, then go to ACQ_IDLE.
REQ-032 abort_i=1 SHALL force ACQ_IDLE next cycle from any state, with no fail_o pulse; it takes priority over every other transition.
REQ-033 If abort_i and res_ready_i are both 1 in ACQ_LOCKED, SHALL count the result as transferred.
REQ-034 start_i outside ACQ_IDLE SHALL be ignored.

Reset
REQ-035 On rst_n=0, SHALL immediately set state to ACQ_IDLE and corr_ready_o, res_valid_o, fail_o, bin_o, phase_o, res_o and all internal registers to 0.
REQ-036 Reset mid-search SHALL discard all progress; no result or fail_o follows the reset release.

Configuration
REQ-037 With ACQ_PEAK_MAG_EN defined, SHALL add output peak_mag_o (MAG_W), equal to the stored best magnitude and 0 after reset; without the macro, the port and its logic SHALL be absent and all other behaviour identical.

Verification
REQ-038 Defaults; threshold 300, sv 5, all cells 10 except bin 2 phase 100 = 500; confirm 400 -> LOCKED; res_o={6'd5, 16'hF060, 10'd100}.
REQ-039 All cells 10, threshold 300 -> ACQ_TIMEOUT after 21*1023 samples; fail_o high exactly 1 cycle; then ACQ_IDLE.
REQ-040 Peak found; three confirm samples of 200 (threshold 300) -> TIMEOUT after 3rd; fail_o pulses once.
REQ-041 Cells bin 0 phase 5 and bin 7 phase 9 both 800 -> confirm cell is bin 0, phase 5 (tie keeps earliest).
REQ-042 LOCKED with res_ready_i=0 for 10 cycles -> res_o stable and res_valid_o=1 throughout; res_ready_i=1 -> ACQ_IDLE next cycle.
REQ-043 abort_i during SEARCH at bin 4 -> ACQ_IDLE next cycle, fail_o=0; rst_n low mid-CONFIRM -> all outputs 0 immediately.
